data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, extra SRAM access cycles beyond the minimum; legal range 0..7.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  1  access request from the EXE stage; level-sensitive.
REQ-005 we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 addr  input  18  word address; sampled with req.
REQ-007 wdata  input  16  write data; sampled with req.
REQ-008 busy  output  1  high whenever state is not IDLE; drives pipeline hold.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  16  read result; valid while done=1 after a read.
REQ-011 ram_addr  output  18  SRAM address.
REQ-012 ram_data  inout  16  SRAM data bus.
REQ-013 ram_en  output  1  SRAM chip enable, active-low.
REQ-014 ram_oe  output  1  SRAM output enable, active-low.
REQ-015 ram_rw  output  1  SRAM write enable, active-low (0 = write strobe).

Function
REQ-016 States SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE; all outputs registered.
REQ-017 IDLE: req=1 at a rising edge latches we/addr/wdata; next state is RD (we=0) or WR_SETUP (we=1); req=0 stays IDLE.
REQ-018 req while not IDLE SHALL be ignored; the requester holds req until done; a req still high in the cycle after DONE starts a new access.
REQ-019 RD: lasts WAIT_CYCLES+1 cycles; ram_en=0, ram_oe=0, ram_rw=1, ram_addr=latched addr, ram_data high-Z.
REQ-020 RD: the edge leaving the last RD cycle SHALL capture ram_data into rdata; next state DONE.
REQ-021 WR_SETUP: 1 cycle; ram_en=0, ram_oe=1, ram_rw=1, ram_addr and ram_data driven with latched values.
REQ-022 WR_PULSE: WAIT_CYCLES+1 cycles; as WR_SETUP except ram_rw=0.
REQ-023 WR_HOLD: 1 cycle; ram_rw=1, ram_en=0, addr and data still driven; next state DONE.
REQ-024 DONE: 1 cycle; done=1, busy=1, ram_en=ram_oe=ram_rw=1, ram_data high-Z; next state IDLE.
REQ-025 ram_data SHALL be driven only in WR_SETUP, WR_PULSE and WR_HOLD; high-Z in all other states.
REQ-026 ram_rw=0 and ram_oe=0 SHALL never be asserted in the same cycle.
REQ-027 Wait counter is 3 bits, loaded with WAIT_CYCLES on entry to RD or WR_PULSE; the state is left when the counter reads 0.
REQ-028 Latency, request accepted at edge t: read done=1 in cycle t+WAIT_CYCLES+2; write done=1 in cycle t+WAIT_CYCLES+4.
REQ-029 rdata SHALL hold its last captured value until the next read capture; writes do not change it.
REQ-030 busy SHALL rise in the cycle after acceptance and fall in the cycle after DONE.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE regardless of current state, including mid-write.
REQ-032 Reset values: busy=0, done=0, rdata=0x0000, ram_addr=0, ram_en=1, ram_oe=1, ram_rw=1, ram_data high-Z, wait counter=0.
REQ-033 A req present in the same cycle as rst SHALL be dropped.

Verification
REQ-034 WAIT_CYCLES=1, read addr=0x00012 with SRAM model returning 0xBEEF -> ram_oe low for 2 cycles; done=1 with rdata=0xBEEF 3 cycles after accept.
REQ-035 WAIT_CYCLES=1, write addr=0x3FFFF, wdata=0x1234 -> ram_rw low for exactly 2 cycles, data driven for 4 cycles; done 5 cycles after accept; model holds 0x1234.
REQ-036 Back-to-back: write 0xA5A5 to 0x00100, then req held for a read of 0x00100 -> second accept in the cycle after DONE; rdata=0xA5A5.
REQ-037 rst pulsed during WR_PULSE -> next cycle ram_rw=1, ram_en=1, ram_data high-Z, busy=0, and no done pulse.
REQ-038 WAIT_CYCLES=0 read, then req toggled while busy -> read done 2 cycles after accept; mid-access req changes have no effect.
REQ-039 Every test: checker flags any cycle with ram_oe=0 and ram_rw=0 together, or ram_data driven outside the write states.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns a level-sensitive EXE-stage request into a timed
// asynchronous SRAM read or write cycle. Every SRAM-side and status output is a flop.
module data_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [17:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic [17:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_en,
  output logic        ram_oe,
  output logic        ram_rw
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  wait_cnt;
  logic [2:0]  wait_next;
  logic [15:0] wdata_q;
  logic        drive;
  logic        drive_next;
  logic        en_next;
  logic        oe_next;
  logic        rw_next;
  logic        accept;
  logic        capture;

  assign accept   = (state == IDLE) && req;
  assign capture  = (state == RD) && (wait_cnt == 3'd0);
  assign ram_data = drive ? wdata_q : 16'hzzzz;

  // Strobes are decoded from the state being entered so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    en_next    = 1'b1;
    oe_next    = 1'b1;
    rw_next    = 1'b1;
    drive_next = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (we) begin
            state_next = WR_SETUP;
          end else begin
            state_next = RD;
            wait_next  = WAIT_LOAD;
          end
        end
      end
      RD: begin
        if (wait_cnt == 3'd0) begin
          state_next = DONE;
        end else begin
          wait_next = wait_cnt - 3'd1;
        end
      end
      WR_SETUP: begin
        state_next = WR_PULSE;
        wait_next  = WAIT_LOAD;
      end
      WR_PULSE: begin
        if (wait_cnt == 3'd0) begin
          state_next = WR_HOLD;
        end else begin
          wait_next = wait_cnt - 3'd1;
        end
      end
      WR_HOLD: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    case (state_next)
      RD: begin
        en_next = 1'b0;
        oe_next = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        en_next    = 1'b0;
        drive_next = 1'b1;
      end
      WR_PULSE: begin
        en_next    = 1'b0;
        rw_next    = 1'b0;
        drive_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and write data are latched once at acceptance so the requester
  // may change them freely while the access is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= 16'h0000;
      ram_addr <= 18'h00000;
      wdata_q  <= 16'h0000;
      drive    <= 1'b0;
      ram_en   <= 1'b1;
      ram_oe   <= 1'b1;
      ram_rw   <= 1'b1;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      busy     <= (state_next != IDLE);
      done     <= (state_next == DONE);
      drive    <= drive_next;
      ram_en   <= en_next;
      ram_oe   <= oe_next;
      ram_rw   <= rw_next;
      if (accept) begin
        ram_addr <= addr;
        wdata_q  <= wdata;
      end
      if (capture) begin
        rdata <= ram_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance with WAIT_CYCLES=1 and one with 0, each on its own
// SRAM model, checked every cycle against a latency-based reference model.
module tb_data_mem_ctrl;

  logic clk;
  logic rst;
  logic [1:0]        req_v;
  logic [1:0]        we_v;
  logic [1:0][17:0]  addr_v;
  logic [1:0][15:0]  wdata_v;

  logic        busy0, done0, ram_en0, ram_oe0, ram_rw0;
  logic        busy1, done1, ram_en1, ram_oe1, ram_rw1;
  logic [15:0] rdata0, rdata1;
  logic [17:0] ram_addr0, ram_addr1;
  wire  [15:0] ram_data0;
  wire  [15:0] ram_data1;

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 0;

  int          wc [2] = '{0, 1};
  int          k  [2] = '{0, 0};
  bit          op_we [2] = '{1'b0, 1'b0};
  logic [17:0] exp_addr [2] = '{18'h0, 18'h0};
  logic [15:0] op_wdata [2] = '{16'h0, 16'h0};
  logic [15:0] exp_rdata [2] = '{16'h0, 16'h0};
  logic [1:0]  exp_drv = 2'b00;
  logic [15:0] ref_mem [int];

  wire [1:0]       busy_w  = {busy1, busy0};
  wire [1:0]       done_w  = {done1, done0};
  wire [1:0]       en_w    = {ram_en1, ram_en0};
  wire [1:0]       oe_w    = {ram_oe1, ram_oe0};
  wire [1:0]       rw_w    = {ram_rw1, ram_rw0};
  wire [1:0][15:0] rdata_w = {rdata1, rdata0};
  wire [1:0][17:0] raddr_w = {ram_addr1, ram_addr0};
  wire [1:0][15:0] bus_w   = {ram_data1, ram_data0};

  wire sram_rd0 = !ram_en0 && !ram_oe0 && ram_rw0;
  wire sram_rd1 = !ram_en1 && !ram_oe1 && ram_rw1;

  // SRAM drives reads; otherwise the bench holds the bus at 0 wherever the DUT must be high-Z.
  assign ram_data0 = sram_rd0 ? mem0[ram_addr0] : (exp_drv[0] ? 16'hzzzz : 16'h0000);
  assign ram_data1 = sram_rd1 ? mem1[ram_addr1] : (exp_drv[1] ? 16'hzzzz : 16'h0000);

  data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
    .busy(busy0), .done(done0), .rdata(rdata0), .ram_addr(ram_addr0), .ram_data(ram_data0),
    .ram_en(ram_en0), .ram_oe(ram_oe0), .ram_rw(ram_rw0)
  );

  data_mem_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
    .busy(busy1), .done(done1), .rdata(rdata1), .ram_addr(ram_addr1), .ram_data(ram_data1),
    .ram_en(ram_en1), .ram_oe(ram_oe1), .ram_rw(ram_rw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [17:0] a);
    if (a == 18'h00012) return 16'hBEEF;
    return a[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] ref_read(input int u, input logic [17:0] a);
    int key;
    key = u * 262144 + int'(a);
    if (ref_mem.exists(key)) return ref_mem[key];
    return init_val(a);
  endfunction

  // Expected {busy, done, en, oe, rw, drive} for cycle kk after acceptance (0 = idle).
  function automatic logic [5:0] exp_ctl(input int kk, input bit w, input int n);
    int   last;
    logic b, d, en, oe, rw, dv;
    last = w ? n + 4 : n + 2;
    b  = (kk != 0);
    d  = b && (kk == last);
    en = !(b && (w ? (kk <= n + 3) : (kk <= n + 1)));
    oe = !(b && !w && (kk <= n + 1));
    rw = !(w && kk >= 2 && kk <= n + 2);
    dv = w && kk >= 1 && kk <= n + 3;
    return {b, d, en, oe, rw, dv};
  endfunction

  task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input int u);
    logic [5:0]  e;
    logic [15:0] bus_exp;
    string       tag;
    e   = exp_ctl(k[u], op_we[u], wc[u]);
    tag = $sformatf("u%0d@%0t", u, $time);
    if (e[0])       bus_exp = op_wdata[u];
    else if (!e[2]) bus_exp = ref_read(u, exp_addr[u]);
    else            bus_exp = 16'h0000;
    cmp({tag, " busy"},     32'(busy_w[u]),  32'(e[5]));
    cmp({tag, " done"},     32'(done_w[u]),  32'(e[4]));
    cmp({tag, " ram_en"},   32'(en_w[u]),    32'(e[3]));
    cmp({tag, " ram_oe"},   32'(oe_w[u]),    32'(e[2]));
    cmp({tag, " ram_rw"},   32'(rw_w[u]),    32'(e[1]));
    cmp({tag, " ram_data"}, 32'(bus_w[u]),   32'(bus_exp));
    cmp({tag, " rdata"},    32'(rdata_w[u]), 32'(exp_rdata[u]));
    cmp({tag, " ram_addr"}, 32'(raddr_w[u]), 32'(exp_addr[u]));
    cmp({tag, " oe_rw_overlap"}, 32'(!oe_w[u] && !rw_w[u]), 32'd0);
  endtask

  // SRAM models: preload, then store whatever is on the bus mid-cycle while the write strobe is low.
  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem0[i] = init_val(18'(i));
      mem1[i] = init_val(18'(i));
    end
    forever begin
      @(negedge clk);
      if (!ram_en0 && !ram_rw0) mem0[ram_addr0] = ram_data0;
      if (!ram_en1 && !ram_rw1) mem1[ram_addr1] = ram_data1;
    end
  end

  // Reference model: counts cycles since acceptance and derives everything from the access latencies.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rst) begin
          k[u]         = 0;
          exp_addr[u]  = 18'h0;
          exp_rdata[u] = 16'h0;
        end else if (k[u] == 0) begin
          if (req_v[u]) begin
            k[u]        = 1;
            op_we[u]    = we_v[u];
            exp_addr[u] = addr_v[u];
            op_wdata[u] = wdata_v[u];
          end
        end else if (k[u] == (op_we[u] ? wc[u] + 4 : wc[u] + 2)) begin
          k[u] = 0;
        end else begin
          if (!op_we[u] && k[u] == wc[u] + 1) exp_rdata[u] = ref_read(u, exp_addr[u]);
          k[u]++;
          if (op_we[u] && k[u] == 2) ref_mem[u * 262144 + int'(exp_addr[u])] = op_wdata[u];
        end
        e = exp_ctl(k[u], op_we[u], wc[u]);
        exp_drv[u] = e[0];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        for (int u = 0; u < 2; u++) checkOutput(u);
      end
    end
  end

  task automatic applyStimulus(input int u, input bit w, input logic [17:0] a, input logic [15:0] d,
                               input bit hold, input bit toggle,
                               output logic [15:0] rd, output int lat,
                               output int n_oe, output int n_rw, output int n_drv);
    bit seen;
    rd = 16'h0; lat = -1; n_oe = 0; n_rw = 0; n_drv = 0; seen = 0;
    @(negedge clk);
    req_v[u] = 1'b1; we_v[u] = w; addr_v[u] = a; wdata_v[u] = d;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (!oe_w[u]) n_oe++;
      if (!rw_w[u]) n_rw++;
      if (w && bus_w[u] === d) n_drv++;
      if (done_w[u]) begin
        seen = 1;
        lat  = cyc;
        rd   = rdata_w[u];
        if (!hold) req_v[u] = 1'b0;
      end else if (toggle) begin
        req_v[u]   = ~req_v[u];
        we_v[u]    = ~we_v[u];
        addr_v[u]  = 18'($urandom);
        wdata_v[u] = 16'($urandom);
      end
    end
    cmp($sformatf("u%0d done_within_budget", u), 32'(seen), 32'd1);
  endtask

  typedef struct {
    bit          we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        tbl [11];
    logic [17:0] pool [8];
    logic [15:0] rd;
    int          lat, n_oe, n_rw, n_drv;

    tbl[0]  = '{1'b1, 18'h00040, 16'h1111, 16'h0000, 5};
    tbl[1]  = '{1'b0, 18'h00040, 16'h0000, 16'h1111, 3};
    tbl[2]  = '{1'b1, 18'h00041, 16'hFFFF, 16'h1111, 5};
    tbl[3]  = '{1'b0, 18'h00041, 16'h0000, 16'hFFFF, 3};
    tbl[4]  = '{1'b0, 18'h00012, 16'h0000, 16'hBEEF, 3};
    tbl[5]  = '{1'b1, 18'h00000, 16'h0001, 16'hBEEF, 5};
    tbl[6]  = '{1'b0, 18'h00000, 16'h0000, 16'h0001, 3};
    tbl[7]  = '{1'b1, 18'h3FFFF, 16'h8000, 16'h0001, 5};
    tbl[8]  = '{1'b0, 18'h3FFFF, 16'h0000, 16'h8000, 3};
    tbl[9]  = '{1'b0, 18'h00040, 16'h0000, 16'h1111, 3};
    tbl[10] = '{1'b0, 18'h00100, 16'h0000, 16'hA5A5, 3};
    pool = '{18'h00000, 18'h00012, 18'h00040, 18'h00100, 18'h3FFFF, 18'h1F00F, 18'h00041, 18'h2AAAA};

    rst = 1'b1; req_v = 2'b00; we_v = 2'b00; addr_v = '0; wdata_v = '0;
    repeat (2) @(posedge clk);
    mon_on = 1;
    @(negedge clk);
    rst = 1'b0;

    // Read with one wait state from a preloaded location.
    applyStimulus(1, 1'b0, 18'h00012, 16'h0000, 0, 0, rd, lat, n_oe, n_rw, n_drv);
    cmp("rd_beef_rdata", 32'(rd), 32'h0000BEEF);
    cmp("rd_beef_latency", 32'(lat), 32'd3);
    cmp("rd_beef_oe_cycles", 32'(n_oe), 32'd2);

    // Write to the top address; rdata must keep the previous read.
    applyStimulus(1, 1'b1, 18'h3FFFF, 16'h1234, 0, 0, rd, lat, n_oe, n_rw, n_drv);
    cmp("wr_top_latency", 32'(lat), 32'd5);
    cmp("wr_top_rw_cycles", 32'(n_rw), 32'd2);
    cmp("wr_top_drive_cycles", 32'(n_drv), 32'd4);
    cmp("wr_top_rdata_kept", 32'(rd), 32'h0000BEEF);
    cmp("wr_top_sram", 32'(mem1[18'h3FFFF]), 32'h00001234);

    // Back-to-back: req stays high through DONE and becomes a read.
    applyStimulus(1, 1'b1, 18'h00100, 16'hA5A5, 1, 0, rd, lat, n_oe, n_rw, n_drv);
    cmp("b2b_wr_latency", 32'(lat), 32'd5);
    applyStimulus(1, 1'b0, 18'h00100, 16'h0000, 0, 0, rd, lat, n_oe, n_rw, n_drv);
    cmp("b2b_rd_latency", 32'(lat), 32'd3);
    cmp("b2b_rd_rdata", 32'(rd), 32'h0000A5A5);

    // Reset in the middle of the write pulse, with req still asserted alongside it.
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 18'h00200; wdata_v[1] = 16'h5AC3;
    repeat (2) @(negedge clk);
    cmp("mid_wr_rw_low", 32'(ram_rw1), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    cmp("rst_rw", 32'(ram_rw1), 32'd1);
    cmp("rst_en", 32'(ram_en1), 32'd1);
    cmp("rst_busy", 32'(busy1), 32'd0);
    cmp("rst_done", 32'(done1), 32'd0);
    cmp("rst_bus_released", 32'(ram_data1), 32'h00000000);
    cmp("rst_rdata", 32'(rdata1), 32'h00000000);
    rst = 1'b0;
    req_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp($sformatf("post_rst_done_%0d", i), 32'(done1), 32'd0);
      cmp($sformatf("post_rst_busy_%0d", i), 32'(busy1), 32'd0);
    end

    // Zero wait states, with req/we/addr churning while busy.
    applyStimulus(0, 1'b0, 18'h00012, 16'h0000, 0, 1, rd, lat, n_oe, n_rw, n_drv);
    cmp("w0_rd_latency", 32'(lat), 32'd2);
    cmp("w0_rd_rdata", 32'(rd), 32'h0000BEEF);
    cmp("w0_rd_oe_cycles", 32'(n_oe), 32'd1);
    applyStimulus(0, 1'b1, 18'h00777, 16'h3C3C, 0, 1, rd, lat, n_oe, n_rw, n_drv);
    cmp("w0_wr_latency", 32'(lat), 32'd4);
    cmp("w0_wr_rw_cycles", 32'(n_rw), 32'd1);
    cmp("w0_wr_drive_cycles", 32'(n_drv), 32'd3);
    cmp("w0_wr_sram", 32'(mem0[18'h00777]), 32'h00003C3C);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, 0, rd, lat, n_oe, n_rw, n_drv);
      cmp($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      cmp($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rdata));
    end

    // Unconstrained traffic on both units, including stray resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      for (int u = 0; u < 2; u++) begin
        req_v[u]   = ($urandom_range(0, 3) != 0);
        we_v[u]    = 1'($urandom_range(0, 1));
        addr_v[u]  = pool[$urandom_range(0, 7)];
        wdata_v[u] = 16'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    req_v = 2'b00;
    repeat (12) @(negedge clk);
    cmp("final_idle_u0", 32'(busy0), 32'd0);
    cmp("final_idle_u1", 32'(busy1), 32'd0);
    mon_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
